// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator sequencer.
// Holds the keypad codes, the ALU operation encodings and the
// sequencer state enumeration used by calc_sequencer.
package calc_pkg;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_MUL   = 4'd12;
    localparam logic [3:0] KEY_EQ    = 4'd13;
    localparam logic [3:0] KEY_CLR   = 4'd14;
    localparam logic [3:0] KEY_RSV   = 4'd15;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        OP_WAIT = 3'd1,
        ENTER_B = 3'd2,
        ALU_RUN = 3'd3,
        RESULT  = 3'd4,
        ERROR   = 3'd5
    } state_t;

    // Map an operator key to its ALU encoding (only called for 10..12).
    function automatic logic [1:0] op_of_key(input logic [3:0] code);
        case (code)
            KEY_MINUS: op_of_key = OP_SUB;
            KEY_MUL:   op_of_key = OP_MUL;
            default:   op_of_key = OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// bcd_entry_reg: one BCD operand entry register.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   clear           - zero value and digit count
//   load_digit      - shift value left one digit and insert digit in the LSD
//   digit           - BCD digit to insert
//   load_value      - overwrite value with value_in (takes priority)
//   value_in        - full-width BCD value for load_value
//   value, count    - current operand and number of digits entered
// clear and load_digit may be asserted together: the digit is then
// entered into a freshly cleared register.
module bcd_entry_reg #(
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          load_digit,
    input  logic [3:0]                    digit,
    input  logic                          load_value,
    input  logic [4*DIGITS-1:0]           value_in,
    output logic [4*DIGITS-1:0]           value,
    output logic [$clog2(DIGITS+1)-1:0]   count
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    logic [W-1:0]  base_value;
    logic [CW-1:0] base_count;
    logic [W+3:0]  shifted;
    logic          take_digit;

    always_comb begin
        base_value = clear ? '0 : value;
        base_count = clear ? '0 : count;
        shifted    = {base_value, digit};
        // Full registers drop further digits; leading zeros are not counted.
        take_digit = load_digit && (base_count != FULL) &&
                     !((digit == 4'd0) && (base_count == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
            count <= '0;
        end else if (load_value) begin
            // A loaded result counts as a complete entry.
            value <= value_in;
            count <= FULL;
        end else if (take_digit) begin
            value <= shifted[W-1:0];
            count <= base_count + 1'b1;
        end else if (clear) begin
            value <= '0;
            count <= '0;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven calculator sequencer.
// Collects two BCD operands and an operator from keypad strobes, issues
// ALU requests, supports operator chaining and repeat-equals, and keeps
// a sticky error after an ALU fault until the clear key.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   key_valid, key_code        - keypad strobe and code
//   alu_done, alu_err,
//   alu_result                 - ALU completion strobe, fault flag, BCD result
//   alu_start                  - one-cycle ALU request strobe
//   operand_a, operand_b,
//   op_sel                     - operands and operation presented to the ALU
//   ingresar_numero_1_en/2_en  - which operand is the current entry target
//   display_value              - value to show
//   error                      - sticky error indicator
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int HAS_MUL = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic                  alu_done,
    input  logic                  alu_err,
    input  logic [4*DIGITS-1:0]   alu_result,
    output logic                  alu_start,
    output logic [4*DIGITS-1:0]   operand_a,
    output logic [4*DIGITS-1:0]   operand_b,
    output logic [1:0]            op_sel,
    output logic                  ingresar_numero_1_en,
    output logic                  ingresar_numero_2_en,
    output logic [4*DIGITS-1:0]   display_value,
    output logic                  error
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    state_t        state, next_state;
    logic [W-1:0]  result_q, result_nxt;
    logic [1:0]    pending_op, pending_nxt, op_sel_nxt;
    logic          chain_pending, chain_nxt, error_nxt;

    logic          a_clear, a_load_digit, a_load_value;
    logic [W-1:0]  a_value_in;
    logic          b_clear, b_load_digit;
    logic [CW-1:0] a_count, b_count;

    logic is_digit, is_op, is_eq, is_clr;

    // Key 12 is only an operator when multiply is built in; 15 never matches.
    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_op    = key_valid && ((key_code == KEY_PLUS) || (key_code == KEY_MINUS) ||
                                    ((key_code == KEY_MUL) && (HAS_MUL != 0)));
    assign is_eq    = key_valid && (key_code == KEY_EQ);
    assign is_clr   = key_valid && (key_code == KEY_CLR);

    bcd_entry_reg #(.DIGITS(DIGITS)) u_operand_a (
        .clk        (clk),
        .reset      (reset),
        .clear      (a_clear),
        .load_digit (a_load_digit),
        .digit      (key_code),
        .load_value (a_load_value),
        .value_in   (a_value_in),
        .value      (operand_a),
        .count      (a_count)
    );

    bcd_entry_reg #(.DIGITS(DIGITS)) u_operand_b (
        .clk        (clk),
        .reset      (reset),
        .clear      (b_clear),
        .load_digit (b_load_digit),
        .digit      (key_code),
        .load_value (1'b0),
        .value_in   ('0),
        .value      (operand_b),
        .count      (b_count)
    );

    always_comb begin
        next_state   = state;
        a_clear      = 1'b0;
        a_load_digit = 1'b0;
        a_load_value = 1'b0;
        a_value_in   = result_q;
        b_clear      = 1'b0;
        b_load_digit = 1'b0;
        op_sel_nxt   = op_sel;
        pending_nxt  = pending_op;
        chain_nxt    = chain_pending;
        result_nxt   = result_q;
        error_nxt    = error;

        if (is_clr) begin
            // Clear beats everything, including an alu_done in the same cycle.
            next_state  = ENTER_A;
            a_clear     = 1'b1;
            b_clear     = 1'b1;
            op_sel_nxt  = OP_ADD;
            pending_nxt = OP_ADD;
            chain_nxt   = 1'b0;
            result_nxt  = '0;
            error_nxt   = 1'b0;
        end else begin
            case (state)
                ENTER_A: begin
                    if (is_digit) begin
                        a_load_digit = 1'b1;
                    end else if (is_op) begin
                        op_sel_nxt = op_of_key(key_code);
                        b_clear    = 1'b1;
                        next_state = OP_WAIT;
                    end
                end
                OP_WAIT: begin
                    if (is_digit) begin
                        b_load_digit = 1'b1;
                        next_state   = ENTER_B;
                    end else if (is_op) begin
                        op_sel_nxt = op_of_key(key_code);
                    end
                end
                ENTER_B: begin
                    if (is_digit) begin
                        b_load_digit = 1'b1;
                    end else if (is_eq) begin
                        next_state = ALU_RUN;
                    end else if (is_op) begin
                        // Evaluate the current pair first, then continue with the new op.
                        chain_nxt   = 1'b1;
                        pending_nxt = op_of_key(key_code);
                        next_state  = ALU_RUN;
                    end
                end
                ALU_RUN: begin
                    if (alu_done) begin
                        if (alu_err) begin
                            error_nxt  = 1'b1;
                            next_state = ERROR;
                        end else begin
                            result_nxt = alu_result;
                            if (chain_pending) begin
                                a_load_value = 1'b1;
                                a_value_in   = alu_result;
                                b_clear      = 1'b1;
                                op_sel_nxt   = pending_op;
                                chain_nxt    = 1'b0;
                                next_state   = OP_WAIT;
                            end else begin
                                next_state = RESULT;
                            end
                        end
                    end
                end
                RESULT: begin
                    if (is_digit) begin
                        a_clear      = 1'b1;
                        a_load_digit = 1'b1;
                        next_state   = ENTER_A;
                    end else if (is_op) begin
                        a_load_value = 1'b1;
                        op_sel_nxt   = op_of_key(key_code);
                        b_clear      = 1'b1;
                        next_state   = OP_WAIT;
                    end else if (is_eq) begin
                        // Repeat the last operation on the previous result.
                        a_load_value = 1'b1;
                        next_state   = ALU_RUN;
                    end
                end
                ERROR: begin
                    next_state = ERROR;
                end
                default: begin
                    next_state = ENTER_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= ENTER_A;
            result_q             <= '0;
            op_sel               <= OP_ADD;
            pending_op           <= OP_ADD;
            chain_pending        <= 1'b0;
            error                <= 1'b0;
            alu_start            <= 1'b0;
            ingresar_numero_1_en <= 1'b1;
            ingresar_numero_2_en <= 1'b0;
        end else begin
            state                <= next_state;
            result_q             <= result_nxt;
            op_sel               <= op_sel_nxt;
            pending_op           <= pending_nxt;
            chain_pending        <= chain_nxt;
            error                <= error_nxt;
            // ALU_RUN is always left before being re-entered, so this marks entry.
            alu_start            <= (next_state == ALU_RUN) && (state != ALU_RUN);
            ingresar_numero_1_en <= (next_state == ENTER_A) || (next_state == RESULT);
            ingresar_numero_2_en <= (next_state == OP_WAIT) || (next_state == ENTER_B);
        end
    end

    always_comb begin
        case (state)
            ENTER_B: display_value = operand_b;
            RESULT:  display_value = result_q;
            ERROR:   display_value = '0;
            default: display_value = operand_a;
        endcase
    end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the BCD digits per operand (range 1..8).
REQ-002 The block SHALL have parameter HAS_MUL, default 0; 1 enables the multiply key.
REQ-003 The block SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port key_valid  input  1  one-cycle strobe from keypad decoder.
REQ-006 The block SHALL have port key_code  input  4  0-9 digit, 10 plus, 11 minus, 12 mul, 13 equals, 14 clear, 15 reserved.
REQ-007 The block SHALL have port alu_done  input  1  one-cycle strobe, ALU result ready.
REQ-008 The block SHALL have port alu_err  input  1  qualified by alu_done; overflow or illegal result.
REQ-009 The block SHALL have port alu_result  input  4*DIGITS  BCD result.
REQ-010 The block SHALL have port alu_start  output  1  one-cycle strobe requesting an ALU operation.
REQ-011 The block SHALL have port operand_a, operand_b  output  4*DIGITS each  BCD operands to ALU.
REQ-012 The block SHALL have port op_sel  output  2  00 add, 01 sub, 10 mul.
REQ-013 The block SHALL have port ingresar_numero_1_en, ingresar_numero_2_en  output  1 each  entry-target flags.
REQ-014 The block SHALL have port display_value  output  4*DIGITS  value to show.
REQ-015 The block SHALL have port error  output  1  sticky error indicator.

Function
REQ-016 FSM states SHALL be ENTER_A, OP_WAIT, ENTER_B, ALU_RUN, RESULT, ERROR; keys with key_valid=0 are ignored; every accepted key takes effect on the next rising edge.
REQ-017 Digit entry SHALL shift the target operand left one BCD digit and insert the digit in the LSD; per-operand digit count increments; a digit with count==DIGITS is ignored; a 0 with count==0 leaves value and count at 0.
REQ-018 ENTER_A: digit -> operand_a; operator (10, 11, or 12 when HAS_MUL=1) -> op_sel latched, operand_b and its count cleared, go OP_WAIT; equals ignored.
REQ-019 OP_WAIT: digit -> operand_b, go ENTER_B; operator replaces op_sel, stay; equals ignored.
REQ-020 ENTER_B: digit -> operand_b; equals -> go ALU_RUN; operator -> go ALU_RUN with chain_pending=1 and the new op stored as pending_op.
REQ-021 alu_start SHALL be high exactly in the first cycle of each ALU_RUN entry; operand_a, operand_b, op_sel SHALL be stable throughout ALU_RUN.
REQ-022 ALU_RUN, alu_done with alu_err=0: result register <= alu_result; chain_pending=0 -> RESULT; chain_pending=1 -> operand_a <= alu_result, op_sel <= pending_op, operand_b cleared, chain_pending cleared, go OP_WAIT.
REQ-023 ALU_RUN, alu_done with alu_err=1 -> ERROR, error=1; non-clear keys during ALU_RUN are ignored.
REQ-024 RESULT: digit -> operand_a cleared then loaded with digit, go ENTER_A; operator -> operand_a <= result, new op_sel, operand_b cleared, go OP_WAIT; equals -> operand_a <= result, operand_b unchanged, go ALU_RUN (repeat last operation).
REQ-025 ERROR: only clear is accepted; all other keys and alu_done ignored.
REQ-026 Clear (14) in any state SHALL zero operands, counts, result, op_sel, chain_pending, error, go ENTER_A; in ALU_RUN clear wins over a simultaneous alu_done, and a later alu_done is ignored.
REQ-027 Key 12 with HAS_MUL=0 and key 15 SHALL be ignored in every state.
REQ-028 ingresar_numero_1_en=1 in ENTER_A and RESULT, else 0; ingresar_numero_2_en=1 in OP_WAIT and ENTER_B, else 0; both outputs registered.
REQ-029 display_value SHALL be operand_a in ENTER_A/OP_WAIT, operand_b in ENTER_B, result in RESULT, operand_a during ALU_RUN, all zeros in ERROR.

Reset
REQ-030 Reset SHALL be sampled on rising clk only, override all other inputs, and take effect mid-operation, including during ALU_RUN.
REQ-031 Reset values: state ENTER_A, operands/result/counts/display_value 0, op_sel 00, alu_start 0, error 0, ingresar_numero_1_en 1, ingresar_numero_2_en 0.

Structure
REQ-032 Package calc_pkg SHALL hold key-code constants, op_sel encodings and the state enumeration.
REQ-033 Sub-module bcd_entry_reg (parameter DIGITS; load digit, clear, load-value ports; value and count outputs) SHALL be instantiated once per operand.

Verification
REQ-034 Keys 1,2,+,3,= then alu_done with result 0015 -> alu_start one cycle after equals, op_sel 00, operands 0012/0003, state RESULT, display 0015.
REQ-035 DIGITS=4, keys 0,0,9,8,7,6,5 -> operand_a 9876, count 4, fifth digit ignored.
REQ-036 Chaining: 5,+,3,-: alu_done result 0008 -> operand_a 0008, op_sel 01, OP_WAIT, ingresar_numero_2_en 1.
REQ-037 RESULT 0015, = again with operand_b 0003 -> operand_a 0015, new alu_start.
REQ-038 alu_done with alu_err=1 -> error=1, display 0000, digit keys ignored; clear -> ENTER_A, error 0.
REQ-039 Clear with simultaneous alu_done, and reset during ALU_RUN -> all REQ-031 values next cycle, later alu_done ignored.
